// File: rtl/cei_mochila_pkg.sv
// Shared constants and elaboration-time parameter checks for the scratchpad
// responder.
package cei_mochila_pkg;

  localparam logic [31:0] ERR_RDATA   = 32'hBADC_AB1E;
  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 4;

  function automatic bit latency_ok(input int unsigned lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response types shared between the CPU cluster ports and the
// responders that serve them.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted port and
// the pointer moves only when a grant is actually issued.
module obi_rr_arbiter #(
  parameter  int unsigned NPORTS = 3,
  localparam int unsigned IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NPORTS-1:0] req_i,
  input  logic              advance_i,
  output logic [NPORTS-1:0] gnt_o,
  output logic [IW-1:0]     idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;

  always_comb begin : p_search
    logic [IW:0] cand;
    cand  = '0;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NPORTS)) cand = cand - (IW+1)'(NPORTS);
      if (!found && req_i[cand[IW-1:0]]) begin
        found                = 1'b1;
        idx_o                = cand[IW-1:0];
        gnt_o[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (idx_o == IW'(NPORTS - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/obi_scratchpad_responder.sv
// Shared single-ported scratchpad serving NPORTS OBI initiators: one access per
// cycle, round-robin grant, response returned a fixed LATENCY cycles later.
module obi_scratchpad_responder
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned NPORTS    = 3,
  parameter int unsigned NUM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  slave_req_i  [NPORTS],
  output obi_resp_t slave_resp_o [NPORTS]
);

  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  if (!latency_ok(LATENCY) || !is_pow2(NUM_WORDS)) begin : g_param_check
    $error("obi_scratchpad_responder: LATENCY must be 1..4 and NUM_WORDS a power of two");
  end

  logic [NPORTS-1:0] req_vec, gnt_vec, hit;
  logic [IW-1:0]     gnt_idx;
  logic              granted, acc_we, in_range;
  logic [29:0]       word_off;
  logic [AW-1:0]     word_idx;
  logic [31:0]       new_rdata;
  logic [31:0]       mem_q [NUM_WORDS];

  logic              pipe_valid_q [LATENCY];
  logic              pipe_valid_d [LATENCY];
  logic [IW-1:0]     pipe_port_q  [LATENCY];
  logic [IW-1:0]     pipe_port_d  [LATENCY];
  logic [31:0]       pipe_rdata_q [LATENCY];
  logic [31:0]       pipe_rdata_d [LATENCY];

  // Masking req with reset forces gnt low and freezes the pointer during reset.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) req_vec[p] = slave_req_i[p].req & rst_ni;
  end

  obi_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_vec),
    .advance_i (granted),
    .gnt_o     (gnt_vec),
    .idx_o     (gnt_idx)
  );

  always_comb begin
    granted   = |gnt_vec;
    acc_we    = slave_req_i[gnt_idx].we;
    word_off  = 30'((slave_req_i[gnt_idx].addr - BASE_ADDR) >> 2);
    in_range  = (word_off >> AW) == 30'd0;
    word_idx  = word_off[AW-1:0];
    new_rdata = '0;
    if (!acc_we) new_rdata = in_range ? mem_q[word_idx] : ERR_RDATA;
  end

  always_ff @(posedge clk_i) begin
    if (granted && acc_we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (slave_req_i[gnt_idx].be[b]) begin
          mem_q[word_idx][8*b +: 8] <= slave_req_i[gnt_idx].wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    pipe_valid_d[0] = granted;
    pipe_port_d[0]  = gnt_idx;
    pipe_rdata_d[0] = new_rdata;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_valid_d[s] = pipe_valid_q[s-1];
      pipe_port_d[s]  = pipe_port_q[s-1];
      pipe_rdata_d[s] = pipe_rdata_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_valid_q[s] <= 1'b0;
        pipe_port_q[s]  <= '0;
        pipe_rdata_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_valid_q[s] <= pipe_valid_d[s];
        pipe_port_q[s]  <= pipe_port_d[s];
        pipe_rdata_q[s] <= pipe_rdata_d[s];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      hit[p] = pipe_valid_q[LATENCY-1] && (pipe_port_q[LATENCY-1] == IW'(p));
      slave_resp_o[p].gnt    = gnt_vec[p];
      slave_resp_o[p].rvalid = hit[p];
      slave_resp_o[p].rdata  = hit[p] ? pipe_rdata_q[LATENCY-1] : '0;
    end
  end

endmodule

// File: tb/tb_obi_scratchpad_responder.sv
// Directed bench for the scratchpad responder: a transaction-level model
// (grant search, word memory, scheduled responses) checked on every cycle.
module tb_obi_scratchpad_responder;
  import obi_pkg::*;

  localparam int          NP   = 3;
  localparam int          NW   = 1024;
  localparam int          LAT  = 3;
  localparam logic [31:0] BASE = 32'h0002_0000;
  localparam logic [31:0] ERR  = 32'hBADC_AB1E;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  obi_req_t  req_s  [NP];
  obi_resp_t resp_s [NP];

  int total = 0;
  int bad   = 0;

  obi_scratchpad_responder #(
    .NPORTS(NP), .NUM_WORDS(NW), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .slave_req_i  (req_s),
    .slave_resp_o (resp_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model state: last granted port, known memory words, responses due by cycle.
  int                cyc  = 0;
  int                last = NP - 1;
  logic [31:0]       mmem [int unsigned];
  bit                sv  [8];
  int                sp  [8];
  logic [31:0]       sd  [8];
  bit                sdc [8];
  int                glog [$];
  int                rv_cnt  [NP];
  logic [31:0]       last_rd [NP];

  always @(negedge clk) begin : model
    int          eg, slot, ns;
    logic [31:0] off, d, o;
    bit          inr, dc, ev;
    int unsigned w;
    eg = -1;
    slot = cyc % 8;
    if (rst_n) begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (last + k) % NP;
        if (eg < 0 && req_s[p].req) eg = p;
      end
    end
    for (int p = 0; p < NP; p++) begin
      ev = sv[slot] && (sp[slot] == p);
      chk($sformatf("gnt_p%0d", p), 32'(resp_s[p].gnt), 32'(p == eg));
      chk($sformatf("rvalid_p%0d", p), 32'(resp_s[p].rvalid), 32'(ev));
      if (!(ev && sdc[slot])) chk($sformatf("rdata_p%0d", p), resp_s[p].rdata, ev ? sd[slot] : 32'd0);
      if (resp_s[p].gnt) glog.push_back(p);
      if (resp_s[p].rvalid) begin
        rv_cnt[p]++;
        last_rd[p] = resp_s[p].rdata;
      end
    end
    if (!rst_n) begin
      for (int s = 0; s < 8; s++) sv[s] = 1'b0;
      last = NP - 1;
    end else begin
      sv[slot] = 1'b0;
      if (eg >= 0) begin
        off = req_s[eg].addr - BASE;
        inr = off < NW * 4;
        w   = off >> 2;
        d   = 32'd0;
        dc  = 1'b0;
        if (req_s[eg].we) begin
          if (inr) begin
            if (mmem.exists(w) || req_s[eg].be == 4'hF) begin
              o = mmem.exists(w) ? mmem[w] : 32'd0;
              for (int b = 0; b < 4; b++)
                if (req_s[eg].be[b]) o[8*b +: 8] = req_s[eg].wdata[8*b +: 8];
              mmem[w] = o;
            end else begin
              mmem.delete(w);
            end
          end
        end else if (!inr) begin
          d = ERR;
        end else if (mmem.exists(w)) begin
          d = mmem[w];
        end else begin
          dc = 1'b1;
        end
        ns = (cyc + LAT) % 8;
        sv[ns] = 1'b1; sp[ns] = eg; sd[ns] = d; sdc[ns] = dc;
        last = eg;
      end
    end
    cyc++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_s[p].req = 1'b1; req_s[p].we = we; req_s[p].be = be;
    req_s[p].addr = addr; req_s[p].wdata = wdata;
  endtask

  task automatic txn(input int p, input bit we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    set_req(p, we, be, addr, wdata);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_s[p].gnt && n < 10);
    chk($sformatf("gnt_wait_p%0d", p), 32'(resp_s[p].gnt), 32'd1);
    @(posedge clk); #1;
    req_s[p].req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int snap;
    for (int p = 0; p < NP; p++) begin
      req_s[p] = '0;
      rv_cnt[p] = 0;
      last_rd[p] = 32'd0;
    end
    // Reset with requests pending on every port.
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, 4'hF, BASE + 32'h100 + 32'(p * 4), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_gnt", {29'd0, resp_s[2].gnt, resp_s[1].gnt, resp_s[0].gnt}, 32'd0);
    chk("rst_rvalid", {29'd0, resp_s[2].rvalid, resp_s[1].rvalid, resp_s[0].rvalid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt_after_rst", {29'd0, resp_s[2].gnt, resp_s[1].gnt, resp_s[0].gnt}, 32'b001);
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) req_s[p].req = 1'b0;
    idle(LAT + 2);

    // Write then read back.
    txn(0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
    idle(LAT + 1);
    chk("wr_rdata_zero", last_rd[0], 32'd0);
    txn(0, 1'b0, 4'hF, BASE + 32'h10, 32'd0);
    idle(LAT + 1);
    chk("rd_deadbeef", last_rd[0], 32'hDEAD_BEEF);

    // Read in the cycle right after a write to the same word.
    txn(1, 1'b1, 4'hF, BASE + 32'h20, 32'h1234_5678);
    txn(1, 1'b0, 4'hF, BASE + 32'h20, 32'd0);
    idle(LAT + 1);
    chk("raw_hazard", last_rd[1], 32'h1234_5678);

    // Byte enables over a word of all ones.
    txn(2, 1'b1, 4'hF, BASE + 32'h30, 32'hFFFF_FFFF);
    txn(2, 1'b1, 4'b0101, BASE + 32'h30, 32'h1122_3344);
    txn(2, 1'b0, 4'hF, BASE + 32'h30, 32'd0);
    idle(LAT + 1);
    chk("byte_en", last_rd[2], 32'hFF22_FF44);

    // Low address bits ignored; be=0 write is a no-op.
    txn(0, 1'b1, 4'h0, BASE + 32'h10, 32'h0);
    txn(0, 1'b0, 4'hF, BASE + 32'h13, 32'd0);
    idle(LAT + 1);
    chk("be0_and_lowbits", last_rd[0], 32'hDEAD_BEEF);

    // Fairness: last grant on port 2, then all three request for 9 cycles.
    txn(2, 1'b0, 4'hF, BASE + 32'h20, 32'd0);
    idle(LAT + 1);
    glog.delete();
    snap = rv_cnt[0] + rv_cnt[1] + rv_cnt[2];
    set_req(0, 1'b0, 4'hF, BASE + 32'h10, 32'd0);
    set_req(1, 1'b0, 4'hF, BASE + 32'h30, 32'd0);
    set_req(2, 1'b0, 4'hF, BASE + 32'h20, 32'd0);
    repeat (9) @(negedge clk);
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) req_s[p].req = 1'b0;
    idle(LAT + 2);
    chk("fair_count", 32'(glog.size()), 32'd9);
    for (int i = 0; i < 9 && i < glog.size(); i++)
      chk($sformatf("fair_order_%0d", i), 32'(glog[i]), 32'(i % 3));
    chk("fair_rvalids", 32'(rv_cnt[0] + rv_cnt[1] + rv_cnt[2] - snap), 32'd9);
    chk("fair_rd_p0", last_rd[0], 32'hDEAD_BEEF);
    chk("fair_rd_p1", last_rd[1], 32'hFF22_FF44);
    chk("fair_rd_p2", last_rd[2], 32'h1234_5678);

    // Out of range: just past the top, below the base, and an aliasing write.
    txn(1, 1'b0, 4'hF, BASE + NW * 4, 32'd0);
    idle(LAT + 1);
    chk("oor_read_top", last_rd[1], ERR);
    txn(1, 1'b0, 4'hF, BASE - 32'd4, 32'd0);
    idle(LAT + 1);
    chk("oor_read_below", last_rd[1], ERR);
    txn(1, 1'b1, 4'hF, BASE + NW * 4 + 32'h10, 32'h0BAD_0BAD);
    txn(1, 1'b0, 4'hF, BASE + 32'h10, 32'd0);
    idle(LAT + 1);
    chk("oor_write_dropped", last_rd[1], 32'hDEAD_BEEF);
    txn(0, 1'b1, 4'hF, BASE + NW * 4 - 4, 32'hA5A5_5A5A);
    txn(0, 1'b0, 4'hF, BASE + NW * 4 - 4, 32'd0);
    idle(LAT + 1);
    chk("top_word", last_rd[0], 32'hA5A5_5A5A);

    // Reset one cycle after a read grant: the response must never appear.
    txn(1, 1'b0, 4'hF, BASE + 32'h20, 32'd0);
    snap = rv_cnt[0] + rv_cnt[1] + rv_cnt[2];
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(6);
    chk("rst_drops_inflight", 32'(rv_cnt[0] + rv_cnt[1] + rv_cnt[2]), 32'(snap));
    for (int p = NP - 1; p >= 0; p--) set_req(p, 1'b0, 4'hF, BASE + 32'h30, 32'd0);
    @(negedge clk);
    chk("gnt_after_midrst", {29'd0, resp_s[2].gnt, resp_s[1].gnt, resp_s[0].gnt}, 32'b001);
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) req_s[p].req = 1'b0;
    txn(2, 1'b0, 4'hF, BASE + 32'h20, 32'd0);
    idle(LAT + 1);
    chk("mem_survives_rst", last_rd[2], 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
